// File: rtl/chaos_pkg.sv
// Shared types and fixed-point helpers for the logistic-map byte generator.
// The CHAOS_WARMUP_EN build option is handled in logistic_byte_gen.sv.
package chaos_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CALC1,
        ST_CALC2,
        ST_OUT
    } state_t;

    // r is Q2.(RW-2): two integer bits above the binary point
    localparam int unsigned R_INT = 2;

    function automatic int unsigned r_frac(input int unsigned rw);
        return rw - R_INT;
    endfunction

    // Q0.w representation of 1.0, as a 2w-bit value
    function automatic logic [63:0] x_one(input int unsigned w);
        return 64'd1 << w;
    endfunction

    // Fold top byte onto bottom byte of a w-bit state value
    function automatic logic [7:0] fold_byte(input logic [31:0] x, input int unsigned w);
        return x[w-1 -: 8] ^ x[7:0];
    endfunction

endpackage

// File: rtl/logistic_step.sv
// Logistic-map datapath: S1 computes x(1-x), S2 scales by r with saturation
// and zero-fix, then updates x and the folded output byte.
module logistic_step
    import chaos_pkg::*;
#(
    parameter int unsigned XW = 16,
    parameter int unsigned RW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          calc1,
    input  logic          calc2,
    input  logic [XW-1:0] seed,
    input  logic [RW-1:0] r_ctl,
    output logic [XW-1:0] x,
    output logic [7:0]    data_out
);

    localparam int unsigned PW = 2 * XW;
    localparam int unsigned QW = RW + XW;
    localparam logic [PW-1:0] X_ONE = PW'(x_one(XW));

    logic [RW-1:0] r_q;
    logic [XW-1:0] y_q;
    logic [PW-1:0] p;
    logic [QW-1:0] q;
    logic [XW-1:0] x_next;

    assign p = PW'(x) * (X_ONE - PW'(x));
    assign q = QW'(r_q) * QW'(y_q);

    // Integer bits of q set means r*y >= 1.0; clamp to the largest Q0.XW value
    always_comb begin
        x_next = '0;
        if (|(q >> (QW - R_INT)))
            x_next = '1;
        else
            x_next = XW'(q >> r_frac(RW));
        if (x_next == '0)
            x_next = XW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x        <= '0;
            r_q      <= '0;
            y_q      <= '0;
            data_out <= '0;
        end else begin
            if (load) begin
                x   <= (seed == '0) ? XW'(1) : seed;
                r_q <= r_ctl;
            end
            if (calc1)
                y_q <= XW'(p >> XW);
            if (calc2) begin
                x        <= x_next;
                data_out <= fold_byte(32'(x_next), XW);
            end
        end
    end

endmodule

// File: rtl/logistic_byte_gen.sv
// Chaotic byte source: FSM sequencing the logistic_step datapath with a valid/ready output.
// Define CHAOS_WARMUP_EN to discard the first WARMUP iterates after each load.
module logistic_byte_gen
    import chaos_pkg::*;
#(
    parameter int unsigned XW     = 16,
    parameter int unsigned RW     = 16,
    parameter int unsigned WARMUP = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [XW-1:0] seed,
    input  logic [RW-1:0] r_ctl,
    input  logic          ready,
    output logic [7:0]    data_out,
    output logic          valid,
    output logic          busy
);

    state_t state, state_nx;
    logic   load_en, calc1_en, calc2_en;
    logic   warm_pending;
    logic [XW-1:0] x_cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load_en  = 1'b0;
        calc1_en = 1'b0;
        calc2_en = 1'b0;
        case (state)
            ST_IDLE:  state_nx = ST_IDLE;
            ST_LOAD: begin
                load_en  = 1'b1;
                state_nx = ST_CALC1;
            end
            ST_CALC1: begin
                calc1_en = 1'b1;
                state_nx = ST_CALC2;
            end
            ST_CALC2: begin
                calc2_en = 1'b1;
                state_nx = warm_pending ? ST_CALC1 : ST_OUT;
            end
            ST_OUT: begin
                if (ready)
                    state_nx = ST_CALC1;
            end
            default:  state_nx = ST_IDLE;
        endcase
        // start overrides stop, and both override normal sequencing
        if (stop)
            state_nx = ST_IDLE;
        if (start)
            state_nx = ST_LOAD;
    end

    assign valid = (state == ST_OUT);
    assign busy  = (state != ST_IDLE);

`ifdef CHAOS_WARMUP_EN
    localparam int unsigned CNT_W = 16;

    logic [CNT_W-1:0] iter_cnt;
    logic             warming;

    // iter_cnt wraps freely; warming keeps a wrap from re-arming the warm-up
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter_cnt <= '0;
            warming  <= 1'b0;
        end else if (load_en) begin
            iter_cnt <= '0;
            warming  <= (WARMUP != 0);
        end else if (calc2_en) begin
            iter_cnt <= iter_cnt + 1'b1;
            if (warming && (iter_cnt == CNT_W'(WARMUP - 1)))
                warming <= 1'b0;
        end
    end

    assign warm_pending = warming;
`else
    logic warmup_unused;
    assign warmup_unused = (WARMUP != 0);
    assign warm_pending  = 1'b0;
`endif

    logistic_step #(
        .XW(XW),
        .RW(RW)
    ) u_step (
        .clk      (clk),
        .rst      (rst),
        .load     (load_en),
        .calc1    (calc1_en),
        .calc2    (calc2_en),
        .seed     (seed),
        .r_ctl    (r_ctl),
        .x        (x_cur),
        .data_out (data_out)
    );

endmodule

// File: tb/tb_logistic_byte_gen.sv
// Randomized bench for logistic_byte_gen against a real-number-style integer model of the map.
module tb_logistic_byte_gen;

`ifdef CHAOS_WARMUP_EN
    localparam int WARMUP_TB = 4;
`else
    localparam int WARMUP_TB = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] seed = '0;
    logic [15:0] r_ctl = '0;
    logic        ready = 1'b0;
    logic [7:0]  data_out;
    logic        valid;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    logistic_byte_gen #(
        .XW(16),
        .RW(16),
        .WARMUP(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .seed     (seed),
        .r_ctl    (r_ctl),
        .ready    (ready),
        .data_out (data_out),
        .valid    (valid),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // x' = r*x*(1-x) on integers: x/65536 in [0,1), r/16384 in [0,4)
    function automatic logic [15:0] model_next(input logic [15:0] x, input logic [15:0] r);
        longint unsigned xi, ri, y, q, nx;
        xi = x;
        ri = r;
        y  = (xi * (65536 - xi)) / 65536;
        q  = ri * y;
        if (q >= 64'd1073741824)
            nx = 65535;
        else
            nx = q / 16384;
        if (nx == 0)
            nx = 1;
        return nx[15:0];
    endfunction

    function automatic logic [7:0] model_byte(input logic [15:0] x);
        return 8'((x >> 8) ^ (x & 16'h00ff));
    endfunction

    // mode 0: ready high, 1: random ready, 2: ready low for the first 10 valid cycles
    task automatic run_stream(input logic [15:0] s, input logic [15:0] r, input int nbytes,
                              input int mode, input string tag);
        logic [15:0] mx;
        logic [7:0]  held_data;
        bit          held;
        bit          zero_seen;
        int          got, cycles, first_valid, low_cnt;
        mx = (s == 0) ? 16'd1 : s;
        for (int i = 0; i < WARMUP_TB; i++)
            mx = model_next(mx, r);
        start = 1'b1;
        seed  = s;
        r_ctl = r;
        ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_vdrop"}, 32'(valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        got = 0; cycles = 1; first_valid = 0; low_cnt = 0;
        held = 0; zero_seen = 0; held_data = '0;
        while (got < nbytes && cycles < 100 + 40 * nbytes) begin
            if (valid) begin
                if (first_valid == 0) begin
                    first_valid = cycles;
                    check({tag, "_latency"}, 32'(first_valid), 32'(4 + 2 * WARMUP_TB));
                end
                if (dut.x_cur == 16'd0)
                    zero_seen = 1;
                if (held)
                    check({tag, "_hold"}, 32'(data_out), 32'(held_data));
                case (mode)
                    0: ready = 1'b1;
                    1: ready = 1'($urandom_range(0, 1));
                    default: begin
                        ready = (low_cnt >= 10);
                        low_cnt++;
                    end
                endcase
                if (ready) begin
                    mx = model_next(mx, r);
                    check({tag, "_byte"}, 32'(data_out), 32'(model_byte(mx)));
                    got++;
                    held = 0;
                end else begin
                    held      = 1;
                    held_data = data_out;
                end
            end else begin
                if (held)
                    check({tag, "_valid_hold"}, 32'(valid), 32'd1);
                held  = 0;
                ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cycles++;
        end
        if (got < nbytes)
            check({tag, "_timeout"}, 32'(got), 32'(nbytes));
        check({tag, "_x_nonzero"}, 32'(zero_seen), 32'd0);
        ready = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles, input string tag);
        int n;
        n = 0;
        while (!valid && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (!valid)
            check({tag, "_wait_timeout"}, 32'(valid), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Test 1: r=3.0 from x=0.5
        run_stream(16'h8000, 16'hC000, 4, 0, "t1");
`ifndef CHAOS_WARMUP_EN
        start = 1'b1; seed = 16'h8000; r_ctl = 16'hC000;
        @(negedge clk);
        start = 1'b0;
        wait_valid(20, "t1b");
        check("t1_first_literal", 32'(data_out), 32'h00C0);
`endif

        // Test 2: saturation then zero-fix
        run_stream(16'h8000, 16'hFFFF, 4, 0, "t2");
        // Test 3: seed 0 is loaded as 1
        run_stream(16'h0000, 16'hF000, 8, 1, "t3");
        // Test 4: back-pressure for 10 cycles
        run_stream(16'h1234, 16'hE800, 4, 2, "t4");

        // Test 5a: restart mid-OUT with a new seed
        start = 1'b1; seed = 16'h4321; r_ctl = 16'hF800;
        @(negedge clk);
        start = 1'b0;
        wait_valid(30, "t5");
        run_stream(16'h5A5A, 16'hFC00, 4, 1, "t5_restart");

        // stop while holding a byte
        start = 1'b1; seed = 16'h2222; r_ctl = 16'hF000;
        @(negedge clk);
        start = 1'b0;
        wait_valid(30, "t5s");
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_valid", 32'(valid), 32'd0);
        check("stop_busy", 32'(busy), 32'd0);

        // start and stop together: start wins
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("start_wins_busy", 32'(busy), 32'd1);

        // Test 5b: asynchronous reset while in CALC2
        start = 1'b1; seed = 16'h7777; r_ctl = 16'hF400;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_data", 32'(data_out), 32'd0);
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_x", 32'(dut.x_cur), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Randomized streams
        for (int k = 0; k < 6; k++) begin
            logic [15:0] rs, rr;
            rs = 16'($urandom);
            rr = 16'($urandom_range(32'h8000, 32'hFFFF));
            run_stream(rs, rr, 8, 1, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
